alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one registered integer ALU between two requesters (requester 0: execute stage; requester 1: address/branch helper) with round-robin arbitration and per-requester valid/ready handshakes. The block drives the ALU's opcode and operands, tracks the single in-flight operation, and returns each result and its zero flag to the requester that issued it through a one-entry response slot. It sits between the pipeline's issue logic and the ALU instance.

## Interface
- WIDTH, 32, operand/result width
- CTL_W, 4, ALU opcode width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous and active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_ctl / req1_ctl  in  CTL_W  ALU opcode (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester consumes result
- rsp0_data / rsp1_data  out  WIDTH  result
- rsp0_zero / rsp1_zero  out  1  result == 0
- alu_ctl  out  CTL_W  opcode to ALU
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_out  in  WIDTH  ALU registered result (valid one cycle after issue)
- alu_zero  in  1  ALU zero flag for alu_out

## Operation
- Requester i is eligible when req_i_valid=1, its response slot is empty, and no operation for i is in flight.
- Grant: one eligible requester → granted. Both eligible → the one indicated by priority pointer `prio`. After a grant to i, `prio` moves to the other requester; no grant → `prio` unchanged.
- req_i_ready is combinational: 1 only for the granted requester in that cycle; never asserted while the slot is full or i is in flight.
- Issue: in the grant cycle, alu_ctl/alu_a/alu_b are the granted requester's ctl/a/b. No grant → alu_ctl=4'd15 (NOP, ALU yields 0), alu_a=alu_b=0.
- In-flight tracker: `inflight_v`, `inflight_id` set at the end of the grant cycle, cleared one cycle later unless a new grant occurs.
- Capture: when inflight_v=1, alu_out and alu_zero are written into slot inflight_id at the end of that cycle.
- Slot: rsp_i_valid=1 while full; cleared at the end of a cycle with rsp_i_valid & rsp_i_ready. Data held stable while valid.
- Opcodes are passed through unchecked; unsupported codes return 0 with zero=1.
- Back-to-back issue: the ALU accepts a new op every cycle (alternating requesters); one requester alone issues at most once every 3 cycles without same-cycle drain, and every 3 cycles with continuous rsp_ready=1.

## Timing
- Reset values: req*_ready=0, rsp*_valid=0, rsp*_data=0, rsp*_zero=0, alu_ctl=15, alu_a=alu_b=0, prio=0, inflight_v=0.
- Latency: grant at cycle T → ALU result at T+1 → rsp_i_valid=1 at T+2 (rsp_i_data=result).
- Slot drained at T+2 (rsp_ready=1) → requester i eligible again at T+3.
- Simultaneous capture into slot j and drain of slot i (i≠j) both happen in the same cycle.
- RST mid-operation: the in-flight op is dropped, slots cleared; the ALU's stale output in the following cycle is ignored (inflight_v=0).
- RST asserted → req*_ready=0 in that cycle (no grant while RST=1).

## Structure
- Shared package alu_pkg: ALU opcode localparams (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_NOP=15), CTL_W.
- Sub-module alu_rsp_slot: one-entry result buffer (load, data, zero, valid/ready drain), instantiated twice.
- Arbiter, priority pointer and in-flight tracker live in the top module.

## Test plan
- Reset: hold RST 2 cycles with both req valid → all outputs at reset values, no grant, alu_ctl=15.
- Single op: req0 ADD a=5 b=7 at T → req0_ready=1 at T, rsp0_valid=1 at T+2 with data=12, zero=0.
- Contention: both valid from reset, req0 SUB 9-9, req1 OR 0x0F|0xF0 → req0 granted first; rsp0 data=0, zero=1; req1 granted next cycle, rsp1 data=0xFF.
- Backpressure: rsp0_ready=0 for 5 cycles after a result, req0 valid → req0_ready stays 0, rsp0_data held; req1 continues to be granted.
- Round-robin fairness: both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1; SLT 3<4 returns 1.
- Reset mid-flight: grant req1 AND at T, RST at T+1 → rsp1_valid never asserted, both slots empty after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, control width and requester ids.
package alu_pkg;

  localparam int CTL_W = 4;

  localparam logic [CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [CTL_W-1:0] ALU_NOR = 4'd12;
  localparam logic [CTL_W-1:0] ALU_NOP = 4'd15;

  // Identifies which requester owns the operation currently inside the ALU.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry result buffer: loaded with an ALU result, held until the owner drains it.
module alu_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  // Fill on load, empty on a valid/ready handshake; data stays put until the next load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_zero  <= load_zero;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one registered ALU between the execute stage (0) and
// the address/branch helper (1), with one result slot per requester.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CTL_W-1:0] req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CTL_W-1:0] req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic [CTL_W-1:0] alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  import alu_pkg::*;

  logic    prio;
  logic    inflight_v;
  req_id_t inflight_id;
  logic    elig0;
  logic    elig1;
  logic    gnt0;
  logic    gnt1;
  logic    load0;
  logic    load1;

  // Eligibility, round-robin grant and ALU operand mux; a NOP goes out when nobody wins.
  always_comb begin
    elig0   = req0_valid && !rsp0_valid && !(inflight_v && inflight_id == REQ0) && !RST;
    elig1   = req1_valid && !rsp1_valid && !(inflight_v && inflight_id == REQ1) && !RST;
    gnt0    = elig0 && (!elig1 || !prio);
    gnt1    = elig1 && (!elig0 || prio);
    alu_ctl = CTL_W'(ALU_NOP);
    alu_a   = '0;
    alu_b   = '0;
    if (gnt0) begin
      alu_ctl = req0_ctl;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end else if (gnt1) begin
      alu_ctl = req1_ctl;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Priority flips to the other requester after each grant; the tracker remembers the op in the ALU.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio        <= 1'b0;
      inflight_v  <= 1'b0;
      inflight_id <= REQ0;
    end else begin
      inflight_v <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        inflight_id <= gnt1 ? REQ1 : REQ0;
        prio        <= gnt0;
      end
    end
  end

  assign load0 = inflight_v && (inflight_id == REQ0);
  assign load1 = inflight_v && (inflight_id == REQ1);

  alu_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load0),
    .load_data (alu_out),
    .load_zero (alu_zero),
    .rsp_valid (rsp0_valid),
    .rsp_ready (rsp0_ready),
    .rsp_data  (rsp0_data),
    .rsp_zero  (rsp0_zero)
  );

  alu_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load1),
    .load_data (alu_out),
    .load_zero (alu_zero),
    .rsp_valid (rsp1_valid),
    .rsp_ready (rsp1_ready),
    .rsp_data  (rsp1_data),
    .rsp_zero  (rsp1_zero)
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a registered reference ALU attached.
module tb_alu_share_arbiter;

  logic        CLK;
  logic        RST;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;

  int vectorCount = 0;
  int missCount   = 0;

  logic [4:0] bpReq1Ready = 5'b00100;
  logic [4:0] bpReq1Valid = 5'b00111;
  logic [5:0] fairReady0  = 6'b001001;
  logic [5:0] fairReady1  = 6'b010010;

  alu_share_arbiter #(.WIDTH(32), .CTL_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctl   (req0_ctl),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctl   (req1_ctl),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_zero  (rsp0_zero),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_zero  (rsp1_zero),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero)
  );

  // Free-running clock, 10 time units per cycle.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] aluFn(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      4'd0:    aluFn = a & b;
      4'd1:    aluFn = a | b;
      4'd2:    aluFn = a + b;
      4'd6:    aluFn = a - b;
      4'd7:    aluFn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   aluFn = ~(a | b);
      default: aluFn = 32'd0;
    endcase
  endfunction

  // Reference ALU: result registered one cycle after the operands are issued.
  always @(posedge CLK) begin
    alu_out  <= aluFn(alu_ctl, alu_a, alu_b);
    alu_zero <= (aluFn(alu_ctl, alu_a, alu_b) == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0;
    req0_ctl   = c0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_ctl   = c1;
    req1_a     = a1;
    req1_b     = b1;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST        = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(1'b1, 4'd6, 32'd9, 32'd9, 1'b1, 4'd1, 32'h0F, 32'hF0);

    // Reset held two cycles with both requesters asking.
    nextCycle();
    nextCycle();
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("rst_alu_ctl", 32'(alu_ctl), 32'd15);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_rsp0_data", rsp0_data, 32'd0);
    checkOutput("rst_rsp1_data", rsp1_data, 32'd0);
    checkOutput("rst_rsp0_zero", 32'(rsp0_zero), 32'd0);

    // Contention straight out of reset: requester 0 wins first.
    RST = 1'b0;
    applyStimulus(1'b1, 4'd6, 32'd9, 32'd9, 1'b1, 4'd1, 32'h0F, 32'hF0);
    checkOutput("cont_c0_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("cont_c0_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("cont_c0_alu_ctl", 32'(alu_ctl), 32'd6);
    checkOutput("cont_c0_alu_a", alu_a, 32'd9);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'h0F, 32'hF0);
    checkOutput("cont_c1_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("cont_c1_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("cont_c1_req1_ready", 32'(req1_ready), 32'd1);
    checkOutput("cont_c1_alu_ctl", 32'(alu_ctl), 32'd1);
    checkOutput("cont_c1_alu_b", alu_b, 32'hF0);
    nextCycle();
    rsp0_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("cont_c2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("cont_c2_rsp0_data", rsp0_data, 32'd0);
    checkOutput("cont_c2_rsp0_zero", 32'(rsp0_zero), 32'd1);
    checkOutput("cont_c2_rsp1_valid", 32'(rsp1_valid), 32'd0);
    nextCycle();
    rsp1_ready = 1'b1;
    #1;
    checkOutput("cont_c3_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("cont_c3_rsp1_valid", 32'(rsp1_valid), 32'd1);
    checkOutput("cont_c3_rsp1_data", rsp1_data, 32'hFF);
    checkOutput("cont_c3_rsp1_zero", 32'(rsp1_zero), 32'd0);
    checkOutput("cont_c3_idle_ctl", 32'(alu_ctl), 32'd15);
    checkOutput("cont_c3_idle_a", alu_a, 32'd0);
    nextCycle();
    checkOutput("cont_c4_rsp1_valid", 32'(rsp1_valid), 32'd0);

    // Single ADD, then an unsupported opcode once the slot has drained.
    applyStimulus(1'b1, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("single_t0_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("single_t0_alu_ctl", 32'(alu_ctl), 32'd2);
    nextCycle();
    applyStimulus(1'b1, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("single_t1_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("single_t1_rsp0_valid", 32'(rsp0_valid), 32'd0);
    nextCycle();
    checkOutput("single_t2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("single_t2_rsp0_data", rsp0_data, 32'd12);
    checkOutput("single_t2_rsp0_zero", 32'(rsp0_zero), 32'd0);
    checkOutput("single_t2_req0_ready", 32'(req0_ready), 32'd0);
    nextCycle();
    checkOutput("single_t3_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("single_t3_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("single_t3_alu_ctl", 32'(alu_ctl), 32'd3);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("badop_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("badop_rsp0_data", rsp0_data, 32'd0);
    checkOutput("badop_rsp0_zero", 32'(rsp0_zero), 32'd1);
    nextCycle();

    // Backpressure on slot 0 while requester 1 keeps using the ALU.
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'hF0F0, 32'hFF00, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("bp_b0_req0_ready", 32'(req0_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd2, 32'd100, 32'd23);
    checkOutput("bp_b1_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("bp_b1_req1_ready", 32'(req1_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(1'b1, 4'd2, 32'd1, 32'd1, bpReq1Valid[i], 4'd6, 32'd50, 32'd8);
      checkOutput("bp_req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      checkOutput("bp_rsp0_data", rsp0_data, 32'hF000);
      checkOutput("bp_req1_ready", 32'(req1_ready), 32'(bpReq1Ready[i]));
      if (i == 1) checkOutput("bp_rsp1_first", rsp1_data, 32'd123);
      if (i == 4) checkOutput("bp_rsp1_second", rsp1_data, 32'd42);
    end
    nextCycle();
    rsp0_ready = 1'b1;
    #1;
    checkOutput("bp_b7_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("bp_b7_req0_ready", 32'(req0_ready), 32'd0);
    nextCycle();
    checkOutput("bp_b8_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("bp_b8_req0_ready", 32'(req0_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("bp_b10_rsp0_data", rsp0_data, 32'd2);
    nextCycle();

    // Reset arrives the cycle after requester 1 is granted.
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'hFF, 32'h0F);
    checkOutput("rmid_r0_req1_ready", 32'(req1_ready), 32'd1);
    nextCycle();
    RST = 1'b1;
    applyStimulus(1'b1, 4'd2, 32'd2, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("rmid_r1_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rmid_r1_alu_ctl", 32'(alu_ctl), 32'd15);
    nextCycle();
    RST = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("rmid_r2_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rmid_r2_rsp1_valid", 32'(rsp1_valid), 32'd0);
    nextCycle();
    checkOutput("rmid_r3_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rmid_r3_rsp1_data", rsp1_data, 32'd0);

    // Both requesters continuously valid: grants alternate starting with requester 0.
    applyStimulus(1'b1, 4'd7, 32'd3, 32'd4, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("fair_req0_ready", 32'(req0_ready), 32'(fairReady0[i]));
      checkOutput("fair_req1_ready", 32'(req1_ready), 32'(fairReady1[i]));
      if (i == 2) begin
        checkOutput("fair_rsp0_valid", 32'(rsp0_valid), 32'd1);
        checkOutput("fair_slt_3_4", rsp0_data, 32'd1);
      end
      if (i == 3) begin
        checkOutput("fair_rsp1_valid", 32'(rsp1_valid), 32'd1);
        checkOutput("fair_slt_neg1_1", rsp1_data, 32'd1);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    nextCycle();
    nextCycle();
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
